// File: rtl/dat_deserializer.sv
// SD DAT receiver: 1- or 4-lane start/data/CRC/end-bit framing, assembles words MSB-first.
// Define DAT_DESERIALIZER_CRC16_EN to add a per-lane CRC16 check of the data bits.
module dat_deserializer #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 128
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wide_bus,
  input  logic [3:0]        dat_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              block_done,
  output logic              crc_err,
  output logic              busy
);
  localparam int BW = $clog2(WORD_W);
  localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, DATA, CRC, STOP} state_t;
  state_t state, state_nxt;

  logic              wide;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [3:0]        crc_cnt;
  logic [WORD_W-2:0] shift;
  logic [WORD_W-1:0] shift_nxt;
  logic [3:0]        lanes;
  logic              start;
  logic              word_last;
  logic              block_last;
  logic              end_bad;
  logic              crc_bad;

  assign lanes      = wide ? 4'hf : 4'h1;
  assign start      = wide_bus ? (dat_in == 4'h0) : !dat_in[0];
  assign word_last  = bit_cnt == (wide ? BW'(WORD_W/4 - 1)
                                       : BW'(WORD_W - 1));
  assign block_last = word_last &&
                      (word_cnt == WW'(BLOCK_WORDS - 1));
  assign end_bad    = |(lanes & ~dat_in);
  assign shift_nxt  = wide ? {shift[WORD_W-5:0], dat_in}
                           : {shift, dat_in[0]};

  always_ff @(posedge sd_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DATA;
      DATA:    if (block_last) state_nxt = CRC;
      CRC:     if (crc_cnt == 4'hf) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      wide       <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      crc_cnt    <= '0;
      shift      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      block_done <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      block_done <= 1'b0;
      if (!enable || state == IDLE) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        crc_cnt  <= '0;
        if (enable && start) wide <= wide_bus;
      end else begin
        unique case (state)
          DATA: begin
            shift   <= shift_nxt[WORD_W-2:0];
            bit_cnt <= word_last ? '0 : bit_cnt + BW'(1);
            if (word_last) begin
              word_out   <= shift_nxt;
              word_valid <= 1'b1;
              word_cnt   <= block_last ? '0
                                       : word_cnt + WW'(1);
            end
          end
          CRC: crc_cnt <= crc_cnt + 4'd1;
          STOP: begin
            block_done <= 1'b1;
            crc_err    <= end_bad | crc_bad;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DAT_DESERIALIZER_CRC16_EN
  logic [3:0] crc_msb;

  // Inactive lanes still run but are masked by lanes.
  for (genvar l = 0; l < 4; l++) begin : g_crc
    logic [15:0] lfsr;
    always_ff @(posedge sd_clock) begin
      if (reset || !enable || state == IDLE)
        lfsr <= '0;
      else if (state == DATA)
        lfsr <= {lfsr[14:0], 1'b0} ^
                ({16{lfsr[15] ^ dat_in[l]}} & 16'h1021);
      else if (state == CRC)
        lfsr <= {lfsr[14:0], 1'b0};
    end
    assign crc_msb[l] = lfsr[15];
  end

  always_ff @(posedge sd_clock) begin
    if (reset || !enable || state == IDLE)
      crc_bad <= 1'b0;
    else if (state == CRC && |(lanes & (crc_msb ^ dat_in)))
      crc_bad <= 1'b1;
  end
`else
  assign crc_bad = 1'b0;
`endif

endmodule
